// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding memory request, one-entry skid buffer
// between memory and the IF/ID register, branch redirect with late-response drop.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          IW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipeline_stall_n,
    input  logic          branch_taken,
    input  logic [15:0]   branch_target,
    output logic          imem_req,
    output logic [15:0]   imem_addr,
    input  logic          imem_valid,
    input  logic [IW-1:0] imem_rdata,
    output logic          if_id_valid,
    output logic [IW-1:0] if_id_instr,
    output logic [15:0]   if_id_pc
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_WAIT  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   pc_q, pc_d;
    logic          drop_q, drop_d;
    logic          buf_valid_q, buf_valid_d;
    logic [IW-1:0] buf_instr_q, buf_instr_d;
    logic [15:0]   buf_pc_q, buf_pc_d;
    logic          if_id_valid_q, if_id_valid_d;
    logic [IW-1:0] if_id_instr_q, if_id_instr_d;
    logic [15:0]   if_id_pc_q, if_id_pc_d;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        buf_valid_d   = buf_valid_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;
        if_id_valid_d = if_id_valid_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;

        // Never request while a held buffer could be overrun by the response.
        imem_req = (state_q == S_FETCH) && (!buf_valid_q || pipeline_stall_n) && !rst;

        if (branch_taken) begin
            pc_d          = branch_target;
            buf_valid_d   = 1'b0;
            if_id_valid_d = 1'b0;
            if (state_q == S_FETCH) begin
                if (imem_req) begin
                    state_d = S_WAIT;
                    drop_d  = 1'b1;
                end
            end else if (imem_valid) begin
                // Response consumed and discarded right here, nothing left to drop.
                state_d = S_FETCH;
                drop_d  = 1'b0;
            end else begin
                drop_d = 1'b1;
            end
        end else begin
            if (pipeline_stall_n) begin
                if_id_valid_d = buf_valid_q;
                if_id_instr_d = buf_instr_q;
                if_id_pc_d    = buf_pc_q;
                buf_valid_d   = 1'b0;
            end
            if (state_q == S_FETCH) begin
                if (imem_req) begin
                    state_d = S_WAIT;
                end
            end else if (imem_valid) begin
                state_d = S_FETCH;
                drop_d  = 1'b0;
                if (!drop_q) begin
                    buf_valid_d = 1'b1;
                    buf_instr_d = imem_rdata;
                    buf_pc_d    = pc_q;
                    pc_d        = pc_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            drop_q        <= 1'b0;
            buf_valid_q   <= 1'b0;
            buf_instr_q   <= '0;
            buf_pc_q      <= 16'h0000;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= '0;
            if_id_pc_q    <= 16'h0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            buf_valid_q   <= buf_valid_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_valid = if_id_valid_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;

    // A live response must never land on a full buffer that decode is holding.
    a_no_overrun: assert property (@(posedge clk) disable iff (rst)
        !(state_q == S_WAIT && imem_valid && !drop_q && buf_valid_q && !pipeline_stall_n));

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a transaction-level model of the fetch unit.
module tb_if_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall_n, br, valid;
    logic [15:0] tgt, rdata;

    logic        imem_req, if_id_valid;
    logic [15:0] imem_addr, if_id_instr, if_id_pc;
    logic        w_req, w_ifv;
    logic [15:0] w_addr, w_instr, w_pc;

    if_stage dut (
        .clk(clk), .rst(rst), .pipeline_stall_n(stall_n), .branch_taken(br),
        .branch_target(tgt), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(valid), .imem_rdata(rdata), .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc)
    );

    if_stage #(.RESET_PC(16'hFFFF), .IW(16)) dut_w (
        .clk(clk), .rst(rst), .pipeline_stall_n(stall_n), .branch_taken(br),
        .branch_target(tgt), .imem_req(w_req), .imem_addr(w_addr),
        .imem_valid(valid), .imem_rdata(rdata), .if_id_valid(w_ifv),
        .if_id_instr(w_instr), .if_id_pc(w_pc)
    );

    int checks = 0;
    int failures = 0;

    // Model: a pending-request flag, a one-slot buffer and the IF/ID slot.
    logic        m_known = 1'b0;
    logic        m_wait, m_drop, m_bv, m_iv;
    logic [15:0] m_pc, m_bi, m_bp, m_ii, m_ip;

    // Memory: at most one scheduled response.
    logic        pend_active = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] pend_addr;
    int          fixed_delay = 1;
    logic        inject = 1'b0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h0101) ^ 16'h1234;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_cycle(input logic r, input logic s, input logic b, input logic [15:0] t);
        logic        req_exp, got;
        logic [15:0] old_pc;
        @(posedge clk);
        #1;
        rst = r; stall_n = s; br = b; tgt = t;
        valid = 1'b0; rdata = 16'h0000;
        if (r) begin
            pend_active = 1'b0;
        end else if (pend_active) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                valid = 1'b1;
                rdata = mem_word(pend_addr);
                pend_active = 1'b0;
            end
        end
        if (inject && !valid) begin
            valid = 1'b1;
            rdata = 16'hDEAD;
        end
        inject = 1'b0;
        #3;

        req_exp = m_known && !m_wait && (!m_bv || s) && !r;
        if (m_known) begin
            chk1("imem_req", imem_req, req_exp);
            chk16("imem_addr", imem_addr, m_pc);
            chk1("if_id_valid", if_id_valid, m_iv);
            if (m_iv) begin
                chk16("if_id_instr", if_id_instr, m_ii);
                chk16("if_id_pc", if_id_pc, m_ip);
            end
        end

        old_pc = m_pc;
        if (r) begin
            m_known = 1'b1; m_wait = 1'b0; m_drop = 1'b0; m_pc = 16'h0000;
            m_bv = 1'b0; m_bi = 16'h0; m_bp = 16'h0;
            m_iv = 1'b0; m_ii = 16'h0; m_ip = 16'h0;
        end else if (m_known) begin
            got = m_wait && valid;
            if (b) begin
                m_pc = t; m_bv = 1'b0; m_iv = 1'b0;
                if (req_exp) begin
                    m_wait = 1'b1; m_drop = 1'b1;
                end else if (m_wait) begin
                    if (got) begin m_wait = 1'b0; m_drop = 1'b0; end
                    else m_drop = 1'b1;
                end
            end else begin
                if (s) begin
                    m_iv = m_bv; m_ii = m_bi; m_ip = m_bp; m_bv = 1'b0;
                end
                if (got) begin
                    m_wait = 1'b0;
                    if (m_drop) m_drop = 1'b0;
                    else begin
                        m_bv = 1'b1; m_bi = rdata; m_bp = m_pc; m_pc = m_pc + 16'd1;
                    end
                end
                if (req_exp) m_wait = 1'b1;
            end
        end
        if (req_exp) begin
            pend_active = 1'b1;
            pend_addr   = old_pc;
            pend_cnt    = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 3));
        end
    endtask

    initial begin
        rst = 1'b1; stall_n = 1'b1; br = 1'b0; tgt = 16'h0; valid = 1'b0; rdata = 16'h0;

        do_cycle(1, 1, 0, 16'h0);
        do_cycle(1, 1, 0, 16'h0);
        chk1("rst_if_id_valid", if_id_valid, 1'b0);
        chk16("rst_if_id_instr", if_id_instr, 16'h0000);
        chk16("rst_if_id_pc", if_id_pc, 16'h0000);

        do_cycle(0, 1, 0, 16'h0);                       // c0
        chk1("c0_req", imem_req, 1'b1);
        chk16("c0_addr", imem_addr, 16'h0000);
        chk16("wrap_addr0", w_addr, 16'hFFFF);
        do_cycle(0, 1, 0, 16'h0);                       // c1 response
        do_cycle(0, 1, 0, 16'h0);                       // c2
        chk1("c2_req", imem_req, 1'b1);
        chk16("c2_addr", imem_addr, 16'h0001);
        chk16("wrap_addr1", w_addr, 16'h0000);
        do_cycle(0, 0, 0, 16'h0);                       // c3
        chk1("c3_ifv", if_id_valid, 1'b1);
        chk16("c3_instr", if_id_instr, 16'h1234);
        chk16("c3_pc", if_id_pc, 16'h0000);
        for (int i = 4; i < 8; i++) begin
            do_cycle(0, 0, 0, 16'h0);
            chk1("stall_req", imem_req, 1'b0);
            chk1("stall_ifv", if_id_valid, 1'b1);
            chk16("stall_pc", if_id_pc, 16'h0000);
        end
        fixed_delay = 3;
        do_cycle(0, 1, 0, 16'h0);                       // c8 release
        chk1("rel_req", imem_req, 1'b1);
        chk16("rel_addr", imem_addr, 16'h0002);
        do_cycle(0, 1, 1, 16'h0040);                    // c9 branch in wait
        chk1("rel_ifv", if_id_valid, 1'b1);
        chk16("rel_instr", if_id_instr, 16'h1335);
        chk16("rel_pc", if_id_pc, 16'h0001);
        do_cycle(0, 1, 0, 16'h0);                       // c10
        chk1("br_ifv", if_id_valid, 1'b0);
        chk1("br_wait_req", imem_req, 1'b0);
        fixed_delay = 1;
        do_cycle(0, 1, 0, 16'h0);                       // c11 dropped response
        chk1("drop_req", imem_req, 1'b0);
        do_cycle(0, 1, 0, 16'h0);                       // c12
        chk1("br_req", imem_req, 1'b1);
        chk16("br_addr", imem_addr, 16'h0040);
        chk1("br_ifv2", if_id_valid, 1'b0);
        do_cycle(0, 0, 1, 16'h0777);                    // c13 branch + response + stall
        do_cycle(0, 1, 0, 16'h0);                       // c14
        chk1("brv_req", imem_req, 1'b1);
        chk16("brv_addr", imem_addr, 16'h0777);
        chk1("brv_ifv", if_id_valid, 1'b0);
        do_cycle(0, 1, 0, 16'h0);                       // c15
        do_cycle(0, 1, 0, 16'h0);                       // c16
        do_cycle(0, 0, 0, 16'h0);                       // c17
        chk1("pre_rst_ifv", if_id_valid, 1'b1);
        chk16("pre_rst_pc", if_id_pc, 16'h0777);
        do_cycle(1, 0, 0, 16'h0);                       // c18 reset, buffer full
        inject = 1'b1;
        do_cycle(0, 1, 0, 16'h0);                       // c19 spurious response
        chk1("post_rst_ifv", if_id_valid, 1'b0);
        chk1("post_rst_req", imem_req, 1'b1);
        chk16("post_rst_addr", imem_addr, 16'h0000);
        do_cycle(1, 1, 0, 16'h0);                       // c20 reset while waiting
        do_cycle(0, 1, 0, 16'h0);                       // c21
        chk1("wrst_req", imem_req, 1'b1);
        chk16("wrst_addr", imem_addr, 16'h0000);

        fixed_delay = 0;
        for (int i = 0; i < 3000; i++) begin
            do_cycle(logic'($urandom_range(0, 99) == 0),
                     logic'($urandom_range(0, 2) != 0),
                     logic'($urandom_range(0, 7) == 0),
                     16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
